afc_compare_seq: RTL and testbench

Measurement sequencer serving the AFC binary-search band FSM.
- Each `change` pulse from the band FSM starts one comparison: wait for the VCO to settle on the new band, count divided-VCO edges over a fixed reference window, then compare against a target count.
- Returns a one-hot FAST/SLOW/FREEZE verdict with a one-cycle `done` pulse. These feed the band FSM's `comp_in` and `done` inputs directly.

---
 rtl/afc_pkg.sv | 15 +
 rtl/afc_compare_seq_if.sv | 24 ++
 rtl/afc_edge_det.sv | 28 ++
 rtl/afc_compare_seq.sv | 120 ++++++++++++
 tb/tb_afc_compare_seq.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/afc_pkg.sv
// AFC comparison sequencer shared definitions.
// Verdict encodings match the band FSM comp_in inputs.
package afc_pkg;

  localparam logic [2:0] AFC_FAST   = 3'b100;
  localparam logic [2:0] AFC_SLOW   = 3'b010;
  localparam logic [2:0] AFC_FREEZE = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2
  } afc_state_e;

endpackage

// File: rtl/afc_compare_seq_if.sv
// Band-FSM <-> comparison sequencer bundle.
// master: band FSM side, slave: sequencer side.
interface afc_compare_seq_if #(
  parameter int CNT_W = 12
);
  logic             change;
  logic             vco_edge;
  logic [CNT_W-1:0] target_cnt;
  logic [CNT_W-1:0] tol;
  logic [2:0]       comp_out;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] meas_cnt;

  modport master (
    output change, vco_edge, target_cnt, tol,
    input  comp_out, done, busy, meas_cnt
  );

  modport slave (
    input  change, vco_edge, target_cnt, tol,
    output comp_out, done, busy, meas_cnt
  );
endinterface

// File: rtl/afc_edge_det.sv
// 2-flop synchronizer plus rising-edge detector for the
// divided VCO clock (used only with AFC_EDGE_DET_EN).
module afc_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign pulse = sync & ~prev;

endmodule

// File: rtl/afc_compare_seq.sv
// AFC measurement sequencer: settle, count VCO edges, compare.
// AFC_EDGE_DET_EN: treat vco_edge as an async level and detect edges.
module afc_compare_seq
  import afc_pkg::*;
#(
  parameter int CNT_W      = 12,
  parameter int SETTLE_CYC = 16,
  parameter int WIN_CYC    = 256
) (
  input logic              clk,
  input logic              rst,
  afc_compare_seq_if.slave bus
);

  localparam int MAX_CYC =
    (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
  localparam int TMR_W = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic edge_p;

`ifdef AFC_EDGE_DET_EN
  afc_edge_det u_edge_det (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.vco_edge),
    .pulse (edge_p)
  );
`else
  assign edge_p = bus.vco_edge;
`endif

  afc_state_e       state;
  logic [TMR_W-1:0] tmr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W:0]   hi;
  logic [CNT_W:0]   lo;
  logic [CNT_W:0]   cnt_x;
  logic [2:0]       verdict;
  logic [2:0]       comp_q;
  logic             done_q;
  logic             busy_q;
  logic [CNT_W-1:0] meas_q;

  // Saturating count including the edge of the current cycle
  always_comb begin
    cnt_nxt = cnt;
    if (edge_p && (cnt != CNT_MAX))
      cnt_nxt = cnt + 1'b1;
  end

  // One extra bit keeps hi from overflowing and lo from wrapping
  always_comb begin
    hi    = {1'b0, bus.target_cnt} + {1'b0, bus.tol};
    lo    = '0;
    if (bus.tol <= bus.target_cnt)
      lo = {1'b0, bus.target_cnt} - {1'b0, bus.tol};
    cnt_x = {1'b0, cnt_nxt};
    unique case (1'b1)
      (cnt_x > hi): verdict = AFC_FAST;
      (cnt_x < lo): verdict = AFC_SLOW;
      default:      verdict = AFC_FREEZE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      tmr    <= '0;
      cnt    <= '0;
      comp_q <= 3'b000;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      meas_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.change) begin
            state  <= ST_SETTLE;
            tmr    <= TMR_W'(SETTLE_CYC - 1);
            busy_q <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (tmr == '0) begin
            state <= ST_MEASURE;
            tmr   <= TMR_W'(WIN_CYC - 1);
            cnt   <= '0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        ST_MEASURE: begin
          cnt <= cnt_nxt;
          if (tmr == '0) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            comp_q <= verdict;
            meas_q <= cnt_nxt;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.comp_out = comp_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.meas_cnt = meas_q;

endmodule

// File: tb/tb_afc_compare_seq.sv
// Randomized self-checking bench for afc_compare_seq.
// Two instances: CNT_W=8 and CNT_W=4 (saturation) share stimulus.
module tb_afc_compare_seq;

  localparam int SET = 4;
  localparam int WIN = 16;
  localparam int NCY = SET + WIN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic change = 1'b0;
  logic vco = 1'b0;
  int   tgt_a = 8;
  int   tol_a = 1;
  int   tgt_b = 8;
  int   tol_b = 1;

  int total = 0;
  int bad = 0;
  bit pending = 0;
  bit pat [NCY];

  always #5 clk = ~clk;

  afc_compare_seq_if #(.CNT_W(8)) bus_a ();
  afc_compare_seq_if #(.CNT_W(4)) bus_b ();

  assign bus_a.change     = change;
  assign bus_a.vco_edge   = vco;
  assign bus_a.target_cnt = 8'(tgt_a);
  assign bus_a.tol        = 8'(tol_a);
  assign bus_b.change     = change;
  assign bus_b.vco_edge   = vco;
  assign bus_b.target_cnt = 4'(tgt_b);
  assign bus_b.tol        = 4'(tol_b);

  afc_compare_seq #(
    .CNT_W(8), .SETTLE_CYC(SET), .WIN_CYC(WIN)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  afc_compare_seq #(
    .CNT_W(4), .SETTLE_CYC(SET), .WIN_CYC(WIN)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_v(int cnt, int tgt, int tl);
    int lo;
    lo = tgt - tl;
    if (lo < 0) lo = 0;
    if (cnt > tgt + tl) return 3'b100;
    if (cnt < lo) return 3'b010;
    return 3'b001;
  endfunction

  task automatic chk_idle_out(input string tag);
    chk({tag, ".done_a"}, 32'(bus_a.done), 0);
    chk({tag, ".busy_a"}, 32'(bus_a.busy), 0);
    chk({tag, ".comp_a"}, 32'(bus_a.comp_out), 0);
    chk({tag, ".meas_a"}, 32'(bus_a.meas_cnt), 0);
    chk({tag, ".done_b"}, 32'(bus_b.done), 0);
    chk({tag, ".comp_b"}, 32'(bus_b.comp_out), 0);
    chk({tag, ".meas_b"}, 32'(bus_b.meas_cnt), 0);
  endtask

  // mode 0: every n-th cycle; 1: first n measure cycles; 2: random
  task automatic set_pat(input int mode, input int n);
    for (int i = 0; i < NCY; i++) begin
      case (mode)
        0:       pat[i] = (i % n) == 0;
        1:       pat[i] = (i >= SET) && (i < SET + n);
        default: pat[i] = ($urandom_range(99) < n);
      endcase
    end
  endtask

  task automatic run_cmp(input string tag,
                         input bit poke,
                         input bit chain);
    int e;
    int ea;
    int eb;
    if (!pending) begin
      change = 1'b1;
      vco = 1'($urandom);
      @(negedge clk);
    end
    pending = 0;
    change = 1'b0;
    e = 0;
    for (int i = 0; i < NCY; i++) begin
      chk({tag, ".busy"}, 32'(bus_a.busy), 1);
      chk({tag, ".nodone"}, 32'(bus_a.done | bus_b.done), 0);
      vco = pat[i];
      change = poke && (i == 1 || i == 9 || i == NCY - 1);
      if (i >= SET && pat[i]) e++;
      @(negedge clk);
    end
    change = 1'b0;
    vco = 1'b0;
    ea = (e > 255) ? 255 : e;
    eb = (e > 15) ? 15 : e;
    chk({tag, ".done_a"}, 32'(bus_a.done), 1);
    chk({tag, ".done_b"}, 32'(bus_b.done), 1);
    chk({tag, ".idle"}, 32'(bus_a.busy), 0);
    chk({tag, ".meas_a"}, 32'(bus_a.meas_cnt), 32'(ea));
    chk({tag, ".comp_a"}, 32'(bus_a.comp_out),
        32'(ref_v(ea, tgt_a, tol_a)));
    chk({tag, ".meas_b"}, 32'(bus_b.meas_cnt), 32'(eb));
    chk({tag, ".comp_b"}, 32'(bus_b.comp_out),
        32'(ref_v(eb, tgt_b, tol_b)));
    if (chain) begin
      change = 1'b1;
      pending = 1;
    end
    @(negedge clk);
    change = 1'b0;
    chk({tag, ".done_off"}, 32'(bus_a.done), 0);
    chk({tag, ".busy_next"}, 32'(bus_a.busy), 32'(chain));
    chk({tag, ".hold_a"}, 32'(bus_a.meas_cnt), 32'(ea));
  endtask

  task automatic run_reset_mid();
    change = 1'b1;
    @(negedge clk);
    change = 1'b0;
    for (int i = 0; i < SET + 6; i++) begin
      vco = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk_idle_out("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NCY + 5; i++) begin
      chk("rst_mid.nodone", 32'(bus_a.done | bus_b.done), 0);
      chk("rst_mid.nobusy", 32'(bus_a.busy), 0);
      @(negedge clk);
    end
    vco = 1'b0;
    chk_idle_out("rst_after");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_idle_out("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_out("post_rel");

    set_pat(0, 2);
    run_cmp("freeze_half", 0, 0);

    tgt_b = 12; tol_b = 2;
    set_pat(0, 1);
    run_cmp("fast_sat", 0, 0);
    tgt_b = 8; tol_b = 1;
    set_pat(0, 4);
    run_cmp("slow_q", 0, 0);

    set_pat(1, 9);  run_cmp("edge9", 0, 0);
    set_pat(1, 10); run_cmp("edge10", 0, 0);
    set_pat(1, 7);  run_cmp("edge7", 0, 0);
    set_pat(1, 6);  run_cmp("edge6", 0, 0);

    tgt_a = 0; tol_a = 1; tgt_b = 0; tol_b = 1;
    set_pat(1, 0);
    run_cmp("clamp0", 0, 0);

    tgt_a = 255; tol_a = 5; tgt_b = 15; tol_b = 5;
    set_pat(1, 16);
    run_cmp("ovf255", 0, 0);

    tgt_a = 8; tol_a = 1; tgt_b = 8; tol_b = 1;
    set_pat(2, 50);
    run_cmp("poke", 1, 0);
    set_pat(0, 2);
    run_cmp("chain1", 0, 1);
    set_pat(1, 10);
    run_cmp("chain2", 0, 0);

    for (int r = 0; r < 24; r++) begin
      tgt_a = $urandom_range(20);
      tol_a = $urandom_range(4);
      tgt_b = $urandom_range(15);
      tol_b = $urandom_range(15);
      set_pat(2, $urandom_range(100));
      run_cmp("rand", r % 5 == 2, r % 4 == 1);
    end
    if (pending) begin
      set_pat(2, 50);
      run_cmp("rand_tail", 0, 0);
    end

    run_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
